uart_tx_queue: RTL and testbench

- Buffered transmit front-end that sits directly upstream of the uart core's transmit side.
- Producers push bytes at any rate up to one per clk; the block drains them one at a time into the core's transmit/tx_byte inputs, pacing itself on is_transmitting.
- It replaces direct single-byte transmit driving, so bursts such as echoed strings or status messages are not lost while the line is busy.

---
 rtl/uart_pkg.sv | 17 +
 rtl/byte_fifo.sv | 108 ++++++++++
 rtl/uart_tx_queue.sv | 135 +++++++++++++
 tb/tb_uart_tx_queue.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit queue: drain FSM state encoding,
// byte width and the ASCII line-ending constants.
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
    localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;

    // Drain FSM states; encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        WAIT_DONE  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte buffer with registered occupancy count, combinational
// full/empty decode and a sticky overflow flag for dropped pushes.
// The head entry is always visible on rd_data; rd_en consumes it.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam logic [ADDR_W:0]   DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1'b1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1'b1);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    logic push_s;
    logic pop_s;
    logic drop_s;

    // Full is judged on the registered count, so a push at full is dropped
    // even if the head is being popped in the same cycle.
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == {(ADDR_W + 1){1'b0}});
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = mem_q[rd_ptr_q];

    assign push_s = wr_en & ~full;
    assign drop_s = wr_en & full;
    assign pop_s  = rd_en & ~empty;

    // Next-state for storage, pointers, occupancy and the sticky overflow.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Storage and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q   <= {ADDR_W{1'b0}};
            rd_ptr_q   <= {ADDR_W{1'b0}};
            count_q    <= {(ADDR_W + 1){1'b0}};
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Buffered transmit front-end for the uart core. Bytes are queued in a
// byte_fifo and handed to the core one at a time: a single-cycle transmit
// pulse with tx_byte held until the next pulse, then the FSM waits for
// is_transmitting to rise and fall before looking at the queue again.
// Optional build macro UART_TX_QUEUE_CRLF_EN: a queued LF is preceded on the
// line by an inserted CR (the LF stays at the head until the CR is sent).
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              transmit,
    output logic [BYTE_W-1:0] tx_byte,
    input  logic              is_transmitting
);

    tx_state_e         state_q, state_d;
    logic              transmit_q, transmit_d;
    logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic [BYTE_W-1:0] head_s;
    logic              pop_s;
    logic              empty_s;
`ifdef UART_TX_QUEUE_CRLF_EN
    logic              cr_sent_q, cr_sent_d;
`endif

    byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop_s),
        .rd_data  (head_s),
        .full     (full),
        .empty    (empty_s),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    assign empty    = empty_s;
    assign transmit = transmit_q;
    assign tx_byte  = tx_byte_q;

    // Drain FSM: start a byte from IDLE, then track the core's busy flag.
    always_comb begin
        state_d    = state_q;
        transmit_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        pop_s      = 1'b0;
`ifdef UART_TX_QUEUE_CRLF_EN
        cr_sent_d  = cr_sent_q;
`endif

        case (state_q)
            IDLE: begin
                if (!empty_s) begin
`ifdef UART_TX_QUEUE_CRLF_EN
                    if ((head_s == ASCII_LF) && !cr_sent_q) begin
                        // Send the CR first; the LF stays queued.
                        tx_byte_d = ASCII_CR;
                        cr_sent_d = 1'b1;
                    end else begin
                        tx_byte_d = head_s;
                        pop_s     = 1'b1;
                        cr_sent_d = 1'b0;
                    end
`else
                    tx_byte_d = head_s;
                    pop_s     = 1'b1;
`endif
                    transmit_d = 1'b1;
                    state_d    = WAIT_START;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_START: begin
                if (is_transmitting) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_START;
                end
            end
            WAIT_DONE: begin
                if (!is_transmitting) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs to the uart core.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            transmit_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            transmit_q <= transmit_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

`ifdef UART_TX_QUEUE_CRLF_EN
    // Remembers that the CR for the current head LF has gone out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cr_sent_q <= 1'b0;
        end else begin
            cr_sent_q <= cr_sent_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: table of single-byte latency
// vectors, a uart core model with a scoreboard of expected line bytes,
// and hand-written sequences for overflow, pop-at-full, reset and CRLF.
module tb_uart_tx_queue;

    localparam int DEPTH       = 16;
    localparam int ADDR_W      = 4;
    localparam int FAST_FRAME  = 20;
    localparam int LONG_FRAME  = 300;
    localparam int SLOW_FRAME  = 12500; // 10 bits x 1250 clk/bit (12 MHz / 9600)

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              ovf_clr;
    logic              transmit;
    logic [7:0]        tx_byte;
    logic              is_transmitting = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [7:0] sb [$];
    int frame_len  = FAST_FRAME;
    int busy_cnt   = 0;
    int pulse_cnt  = 0;
    bit rose_seen  = 1'b1;
    bit fell_seen  = 1'b1;

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs [5];

    uart_tx_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .full            (full),
        .empty           (empty),
        .count           (count),
        .overflow        (overflow),
        .ovf_clr         (ovf_clr),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (is_transmitting)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Uart core model and line monitor, evaluated away from the active edge.
    always @(negedge clk) begin
        if (transmit === 1'b1) begin
            pulse_cnt++;
            check("pulse_line_idle", (busy_cnt == 0), 1'b1);
            check("pulse_after_prev_frame", (rose_seen && fell_seen), 1'b1);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got tx_byte 0x%0h, expected no pulse", tx_byte);
            end else begin
                check("tx_byte_order", tx_byte, sb.pop_front());
            end
            rose_seen = 1'b0;
            fell_seen = 1'b0;
        end
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                is_transmitting = 1'b0;
                fell_seen       = 1'b1;
            end
        end else if (transmit === 1'b1) begin
            is_transmitting = 1'b1;
            busy_cnt        = frame_len;
            rose_seen       = 1'b1;
        end
    end

    // Push one byte (sampled at the next edge); returns #1 after that edge.
    task automatic push(input logic [7:0] d, input bit dropped, input bit track);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (!dropped && track) begin
            sb.push_back(d);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((sb.size() != 0 || is_transmitting || count != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, (sb.size() != 0 || is_transmitting || count != 0), 1'b0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_tx_level(input logic lvl, input int budget, input string name);
        int n = 0;
        while (is_transmitting !== lvl && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, is_transmitting, lvl);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;

        vecs[0] = '{data: 8'h41, exp_byte: 8'h41};
        vecs[1] = '{data: 8'h00, exp_byte: 8'h00};
        vecs[2] = '{data: 8'hFF, exp_byte: 8'hFF};
        vecs[3] = '{data: 8'h5A, exp_byte: 8'h5A};
        vecs[4] = '{data: 8'h0D, exp_byte: 8'h0D};

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_transmit", transmit, 1'b0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_count", count, 5'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-byte latency vectors.
        for (int i = 0; i < 5; i++) begin
            push(vecs[i].data, 1'b0, 1'b1);
            check("lat_count_after_push", count, 5'd1);
            check("lat_empty_after_push", empty, 1'b0);
            check("lat_no_pulse_yet", transmit, 1'b0);
            @(posedge clk);
            #1;
            check("lat_pulse", transmit, 1'b1);
            check("lat_tx_byte", tx_byte, vecs[i].exp_byte);
            check("lat_count_drained", count, 5'd0);
            check("lat_empty_drained", empty, 1'b1);
            @(posedge clk);
            #1;
            check("lat_pulse_one_cycle", transmit, 1'b0);
            wait_idle(200, "lat_idle");
        end

        // Back-to-back burst at 9600 baud / 12 MHz.
        frame_len = SLOW_FRAME;
        pc = pulse_cnt;
        push(8'h48, 1'b0, 1'b1);
        push(8'h49, 1'b0, 1'b1);
        push(8'h21, 1'b0, 1'b1);
        wait_idle(3 * SLOW_FRAME + 200, "burst_idle");
        check("burst_pulses", pulse_cnt - pc, 3);
        check("burst_tx_last", tx_byte, 8'h21);

        // Fill while the line is busy, overflow on the 17th push.
        frame_len = LONG_FRAME;
        push(8'h55, 1'b0, 1'b1);
        wait_tx_level(1'b1, 20, "fill_line_busy");
        for (int i = 0; i < DEPTH; i++) begin
            push(8'h60 + 8'(i), 1'b0, 1'b1);
        end
        check("fill_full", full, 1'b1);
        check("fill_count", count, 5'd16);
        check("fill_no_ovf_yet", overflow, 1'b0);
        push(8'h99, 1'b1, 1'b1);
        check("ovf_set", overflow, 1'b1);
        check("ovf_count", count, 5'd16);
        check("ovf_full", full, 1'b1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 1'b0);

        // Push at full in the same cycle as the IDLE pop.
        frame_len = FAST_FRAME;
        wait_tx_level(1'b0, LONG_FRAME + 50, "fill_line_free");
        push(8'hEE, 1'b1, 1'b1);
        check("popfull_pulse", transmit, 1'b1);
        check("popfull_count", count, 5'd15);
        check("popfull_ovf", overflow, 1'b1);
        check("popfull_full", full, 1'b0);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        wait_idle(2000, "fill_drain_idle");

        // Reset while waiting for the core to finish, 5 bytes still queued.
        frame_len = LONG_FRAME;
        for (int i = 0; i < 6; i++) begin
            push(8'h30 + 8'(i), 1'b0, 1'b1);
        end
        wait_tx_level(1'b1, 20, "rstmid_line_busy");
        repeat (3) @(posedge clk);
        #1;
        check("rstmid_count_before", count, 5'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check("rstmid_count", count, 5'd0);
        check("rstmid_empty", empty, 1'b1);
        check("rstmid_transmit", transmit, 1'b0);
        pc = pulse_cnt;
        repeat (LONG_FRAME + 100) @(posedge clk);
        #1;
        check("rstmid_no_pulses", pulse_cnt - pc, 0);
        check("rstmid_count_after", count, 5'd0);
        frame_len = FAST_FRAME;

        // Line-ending handling.
        pc = pulse_cnt;
        push(8'h41, 1'b0, 1'b1);
        push(8'h0A, 1'b0, 1'b0);
`ifdef UART_TX_QUEUE_CRLF_EN
        sb.push_back(8'h0D);
        sb.push_back(8'h0A);
        wait_idle(500, "crlf_idle");
        check("crlf_pulses", pulse_cnt - pc, 3);
`else
        sb.push_back(8'h0A);
        wait_idle(500, "crlf_idle");
        check("crlf_pulses", pulse_cnt - pc, 2);
`endif
        check("crlf_last_byte", tx_byte, 8'h0A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
